// File: rtl/axi4_fill_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi4_fill_pkg
// Description : Shared constants and helpers for the AXI4 fill/verify master.
// Revision    : 1.0 - initial release
// ============================================================================
package axi4_fill_pkg;

    localparam logic [1:0] MODE_INC  = 2'd0;
    localparam logic [1:0] MODE_ZERO = 2'd1;
    localparam logic [1:0] MODE_SEED = 2'd2;
    localparam logic [1:0] MODE_ADDR = 2'd3;

    localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b010;

    function automatic int unsigned beats_per_burst(input int unsigned burst_bytes,
                                                    input int unsigned dw);
        return burst_bytes / (dw / 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fill_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : fill_pattern_gen
// Description : Per-beat fill pattern generator; one 16-bit word replicated.
// Revision    : 1.0 - initial release
// ============================================================================
module fill_pattern_gen
    import axi4_fill_pkg::*;
#(
    parameter int unsigned DW        = 512,
    parameter logic [15:0] ADDR_INIT = 16'h0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    i_mode,
    input  logic [15:0]   i_seed,
    input  logic          i_restart,
    input  logic          i_advance,
    output logic [DW-1:0] o_word
);

    localparam logic [15:0] c_step = 16'(DW / 8);

    logic [15:0] r_k;
    logic [15:0] r_addr;
    logic [15:0] w_word16;

    // Beat index and beat byte address both wrap at 16 bits.
    always_ff @(posedge clk) begin
        if (rst || i_restart) begin
            r_k    <= 16'd0;
            r_addr <= ADDR_INIT;
        end else if (i_advance) begin
            r_k    <= r_k + 16'd1;
            r_addr <= r_addr + c_step;
        end
    end

    always_comb begin
        w_word16 = 16'd0;
        case (i_mode)
            MODE_INC:  w_word16 = i_seed + r_k;
            MODE_ZERO: w_word16 = 16'd0;
            MODE_SEED: w_word16 = i_seed;
            MODE_ADDR: w_word16 = r_addr;
            default:   w_word16 = 16'd0;
        endcase
    end

    assign o_word = {(DW / 16){w_word16}};

endmodule
`default_nettype wire

// File: rtl/axi4_fill_verify.sv
`default_nettype none
// ============================================================================
// Module      : axi4_fill_verify
// Description : AXI4 master that fills a region in bursts, then optionally
//               reads it back and compares against the regenerated pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_fill_verify
    import axi4_fill_pkg::*;
#(
    parameter int unsigned DW           = 512,
    parameter int unsigned AW           = 19,
    parameter int unsigned BASE_ADDR    = 0,
    parameter int unsigned REGION_BYTES = 524288,
    parameter int unsigned BURST_BYTES  = 4096,
    parameter int unsigned MAX_OUTST    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      mode,
    input  logic [15:0]     seed,
    input  logic            verify,
    output logic            busy,
    output logic            done,
    output logic            resp_err,
    output logic [31:0]     mismatch_cnt,
    output logic [AW-1:0]   first_err_addr,
    output logic [AW-1:0]   M_AXI_AWADDR,
    output logic [7:0]      M_AXI_AWLEN,
    output logic [2:0]      M_AXI_AWSIZE,
    output logic [1:0]      M_AXI_AWBURST,
    output logic [3:0]      M_AXI_AWID,
    output logic [3:0]      M_AXI_AWCACHE,
    output logic [3:0]      M_AXI_AWQOS,
    output logic            M_AXI_AWLOCK,
    output logic [2:0]      M_AXI_AWPROT,
    output logic            M_AXI_AWVALID,
    input  logic            M_AXI_AWREADY,
    output logic [DW-1:0]   M_AXI_WDATA,
    output logic [DW/8-1:0] M_AXI_WSTRB,
    output logic            M_AXI_WLAST,
    output logic            M_AXI_WVALID,
    input  logic            M_AXI_WREADY,
    input  logic [1:0]      M_AXI_BRESP,
    input  logic            M_AXI_BVALID,
    output logic            M_AXI_BREADY,
    output logic [AW-1:0]   M_AXI_ARADDR,
    output logic [7:0]      M_AXI_ARLEN,
    output logic [2:0]      M_AXI_ARSIZE,
    output logic [1:0]      M_AXI_ARBURST,
    output logic [3:0]      M_AXI_ARID,
    output logic [3:0]      M_AXI_ARCACHE,
    output logic [3:0]      M_AXI_ARQOS,
    output logic            M_AXI_ARLOCK,
    output logic [2:0]      M_AXI_ARPROT,
    output logic            M_AXI_ARVALID,
    input  logic            M_AXI_ARREADY,
    input  logic [DW-1:0]   M_AXI_RDATA,
    input  logic [1:0]      M_AXI_RRESP,
    input  logic            M_AXI_RLAST,
    input  logic            M_AXI_RVALID,
    output logic            M_AXI_RREADY
);

    localparam int unsigned   c_beats      = beats_per_burst(BURST_BYTES, DW);
    localparam int unsigned   c_nbursts    = REGION_BYTES / BURST_BYTES;
    localparam int            CW           = $clog2(c_nbursts + 1);
    localparam logic [CW-1:0] c_nb         = CW'(c_nbursts);
    localparam logic [7:0]    c_last_beat  = 8'(c_beats - 1);
    localparam logic [AW-1:0] c_base       = AW'(BASE_ADDR);
    localparam logic [AW-1:0] c_burst_step = AW'(BURST_BYTES);
    localparam logic [AW-1:0] c_beat_step  = AW'(DW / 8);
    localparam logic [2:0]    c_size       = 3'($clog2(DW / 8));
    localparam logic [3:0]    c_max_outst  = 4'(MAX_OUTST);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_write = 2'd1;
    localparam logic [1:0] c_read  = 2'd2;
    localparam logic [1:0] c_fin   = 2'd3;

    logic [1:0]    r_state, w_next_state;
    logic [1:0]    r_mode;
    logic [15:0]   r_seed;
    logic          r_verify;
    logic [CW-1:0] r_aw_cnt, r_b_cnt, r_w_burst, r_ar_cnt, r_r_burst;
    logic [AW-1:0] r_aw_addr, r_ar_addr, r_r_addr;
    logic [3:0]    r_outst;
    logic [7:0]    r_w_beat, r_r_beat;
    logic          r_resp_err;
    logic [31:0]   r_mm_cnt;
    logic [AW-1:0] r_first_err;
    logic [DW-1:0] w_r_exp;
    logic          w_start, w_aw_fire, w_w_fire, w_b_fire, w_ar_fire, w_r_fire, w_r_bad;

    assign w_start   = start && (r_state == c_idle);
    assign w_aw_fire = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_w_fire  = M_AXI_WVALID && M_AXI_WREADY;
    assign w_b_fire  = M_AXI_BVALID && M_AXI_BREADY;
    assign w_ar_fire = M_AXI_ARVALID && M_AXI_ARREADY;
    assign w_r_fire  = M_AXI_RVALID && M_AXI_RREADY;

    // Handshake qualifiers are gated by reset so a mid-run reset drops them at once.
    assign M_AXI_AWVALID = !reset && (r_state == c_write) && (r_aw_cnt != c_nb) &&
                           (r_outst != c_max_outst);
    assign M_AXI_WVALID  = !reset && (r_state == c_write) && (r_w_burst != c_nb);
    assign M_AXI_BREADY  = !reset && (r_state == c_write);
    assign M_AXI_ARVALID = !reset && (r_state == c_read) && (r_ar_cnt != c_nb);
    assign M_AXI_RREADY  = !reset && (r_state == c_read);

    assign M_AXI_AWADDR  = r_aw_addr;
    assign M_AXI_AWLEN   = c_last_beat;
    assign M_AXI_AWSIZE  = c_size;
    assign M_AXI_AWBURST = AXI_BURST_INCR;
    assign M_AXI_AWID    = 4'd0;
    assign M_AXI_AWCACHE = 4'd0;
    assign M_AXI_AWQOS   = 4'd0;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWPROT  = AXI_PROT_DEFAULT;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = (r_w_beat == c_last_beat);
    assign M_AXI_ARADDR  = r_ar_addr;
    assign M_AXI_ARLEN   = c_last_beat;
    assign M_AXI_ARSIZE  = c_size;
    assign M_AXI_ARBURST = AXI_BURST_INCR;
    assign M_AXI_ARID    = 4'd0;
    assign M_AXI_ARCACHE = 4'd0;
    assign M_AXI_ARQOS   = 4'd0;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARPROT  = AXI_PROT_DEFAULT;

    assign busy           = (r_state != c_idle);
    assign done           = !reset && (r_state == c_fin);
    assign resp_err       = r_resp_err;
    assign mismatch_cnt   = r_mm_cnt;
    assign first_err_addr = r_first_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:  if (w_start) w_next_state = c_write;
            c_write: if (r_b_cnt == c_nb) w_next_state = r_verify ? c_read : c_fin;
            c_read:  if (r_r_burst == c_nb) w_next_state = c_fin;
            c_fin:   w_next_state = c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode   <= MODE_INC;
            r_seed   <= 16'd0;
            r_verify <= 1'b0;
        end else if (w_start) begin
            r_mode   <= mode;
            r_seed   <= seed;
            r_verify <= verify;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_start) begin
            r_aw_cnt  <= '0;
            r_aw_addr <= c_base;
            r_b_cnt   <= '0;
            r_outst   <= 4'd0;
            r_w_beat  <= 8'd0;
            r_w_burst <= '0;
        end else begin
            if (w_aw_fire) begin
                r_aw_cnt  <= r_aw_cnt + CW'(1);
                r_aw_addr <= r_aw_addr + c_burst_step;
            end
            if (w_b_fire) r_b_cnt <= r_b_cnt + CW'(1);
            if (w_aw_fire && !w_b_fire) begin
                r_outst <= r_outst + 4'd1;
            end else if (!w_aw_fire && w_b_fire) begin
                r_outst <= r_outst - 4'd1;
            end
            if (w_w_fire) begin
                if (r_w_beat == c_last_beat) begin
                    r_w_beat  <= 8'd0;
                    r_w_burst <= r_w_burst + CW'(1);
                end else begin
                    r_w_beat <= r_w_beat + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_start) begin
            r_ar_cnt  <= '0;
            r_ar_addr <= c_base;
            r_r_beat  <= 8'd0;
            r_r_burst <= '0;
            r_r_addr  <= c_base;
        end else begin
            if (w_ar_fire) begin
                r_ar_cnt  <= r_ar_cnt + CW'(1);
                r_ar_addr <= r_ar_addr + c_burst_step;
            end
            // Burst boundaries follow the beat count so a missing RLAST cannot stall READ.
            if (w_r_fire) begin
                r_r_addr <= r_r_addr + c_beat_step;
                if (r_r_beat == c_last_beat) begin
                    r_r_beat  <= 8'd0;
                    r_r_burst <= r_r_burst + CW'(1);
                end else begin
                    r_r_beat <= r_r_beat + 8'd1;
                end
            end
        end
    end

    assign w_r_bad = (M_AXI_RDATA != w_r_exp) ||
                     ((r_r_beat == c_last_beat) && !M_AXI_RLAST);

    always_ff @(posedge clk) begin
        if (reset || w_start) begin
            r_resp_err  <= 1'b0;
            r_mm_cnt    <= 32'd0;
            r_first_err <= '0;
        end else begin
            if ((w_b_fire && (M_AXI_BRESP != AXI_RESP_OKAY)) ||
                (w_r_fire && (M_AXI_RRESP != AXI_RESP_OKAY))) begin
                r_resp_err <= 1'b1;
            end
            if (w_r_fire && w_r_bad) begin
                if (r_mm_cnt == 32'd0) r_first_err <= r_r_addr;
                if (r_mm_cnt != '1) r_mm_cnt <= r_mm_cnt + 32'd1;
            end
        end
    end

    fill_pattern_gen #(
        .DW        (DW),
        .ADDR_INIT (16'(BASE_ADDR))
    ) u_wgen (
        .clk       (clk),
        .rst       (reset),
        .i_mode    (r_mode),
        .i_seed    (r_seed),
        .i_restart (w_start),
        .i_advance (w_w_fire),
        .o_word    (M_AXI_WDATA)
    );

    fill_pattern_gen #(
        .DW        (DW),
        .ADDR_INIT (16'(BASE_ADDR))
    ) u_rgen (
        .clk       (clk),
        .rst       (reset),
        .i_mode    (r_mode),
        .i_seed    (r_seed),
        .i_restart (w_start),
        .i_advance (w_r_fire),
        .o_word    (w_r_exp)
    );

endmodule
`default_nettype wire
